// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths, default baud divider and tx state encoding (UART_TX_PARITY_EN adds the parity state)
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;

  // One state per frame field; the parity state only exists when parity is built in.
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY_BIT = 3'd3,
`endif
    TX_STOP_BIT   = 3'd4
  } tx_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake and serial line bundle between producer and uart_tx
interface uart_tx_if;
  import uart_pkg::*;

  logic                   i_TX_DV;
  logic [UART_DATA_W-1:0] i_TX_Byte;
  logic                   o_TX_Ready;
  logic                   o_TX_Serial;
  logic                   o_TX_Active;
  logic                   o_TX_Done;

  modport master (
    output i_TX_DV,
    output i_TX_Byte,
    input  o_TX_Ready,
    input  o_TX_Serial,
    input  o_TX_Active,
    input  o_TX_Done
  );

  modport slave (
    input  i_TX_DV,
    input  i_TX_Byte,
    output o_TX_Ready,
    output o_TX_Serial,
    output o_TX_Active,
    output o_TX_Done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts clocks within one bit period and flags its last cycle
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_bit_timer: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] count;

  // Tick marks the final clock of the current bit so the caller advances on that edge.
  assign tick = enable && (count == LAST_COUNT);

  // Free-run 0..CLKS_PER_BIT-1 while enabled, wrapping so consecutive bits abut exactly.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-byte holding register; UART_TX_PARITY_EN adds an even parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_tx_if.slave tx
);

  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(UART_DATA_W - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t              state_q, state_n;
  logic [UART_DATA_W-1:0] shift_q, shift_n;
  logic [UART_DATA_W-1:0] hold_q, hold_n;
  logic                   hold_valid_q, hold_valid_n;
  logic [IDX_W-1:0]       index_q, index_n;
  logic                   serial_q, serial_n;
  logic                   active_q, active_n;
  logic                   done_q, done_n;
  logic                   bit_tick;
  logic                   timer_clear;
  logic                   timer_enable;
  logic                   accept;
  logic                   stop_end;

  assign timer_clear  = (state_q == IDLE);
  assign timer_enable = (state_q != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .tick    (bit_tick)
  );

  assign accept   = tx.i_TX_DV && !hold_valid_q;
  assign stop_end = (state_q == TX_STOP_BIT) && bit_tick;

  // Next-state logic: walks the frame fields and decides where each accepted byte lands.
  always_comb begin
    state_n      = state_q;
    shift_n      = shift_q;
    hold_n       = hold_q;
    hold_valid_n = hold_valid_q;
    index_n      = index_q;
    done_n       = 1'b0;
    serial_n     = 1'b1;

    case (state_q)
      IDLE: begin
        index_n = '0;
        if (accept) begin
          shift_n = tx.i_TX_Byte;
          state_n = TX_START_BIT;
        end
      end
      TX_START_BIT: begin
        if (bit_tick) begin
          index_n = '0;
          state_n = TX_DATA_BITS;
        end
      end
      TX_DATA_BITS: begin
        if (bit_tick) begin
          if (index_q == LAST_INDEX) begin
`ifdef UART_TX_PARITY_EN
            state_n = TX_PARITY_BIT;
`else
            state_n = TX_STOP_BIT;
`endif
          end else begin
            index_n = index_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: begin
        if (bit_tick) begin
          state_n = TX_STOP_BIT;
        end
      end
`endif
      TX_STOP_BIT: begin
        if (bit_tick) begin
          done_n  = 1'b1;
          index_n = '0;
          if (hold_valid_q) begin
            shift_n      = hold_q;
            hold_valid_n = 1'b0;
            state_n      = TX_START_BIT;
          end else if (accept) begin
            shift_n = tx.i_TX_Byte;
            state_n = TX_START_BIT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // While a frame is in flight (and not at the edge that chains directly), park the byte.
    if (accept && (state_q != IDLE) && !stop_end) begin
      hold_n       = tx.i_TX_Byte;
      hold_valid_n = 1'b1;
    end

    // The line is registered from the next state so it changes on the same edge as the state.
    case (state_n)
      TX_START_BIT:  serial_n = 1'b0;
      TX_DATA_BITS:  serial_n = shift_n[index_n];
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: serial_n = even_parity(shift_n);
`endif
      default:       serial_n = 1'b1;
    endcase

    active_n = (state_n != IDLE);
  end

  // State and output registers; reset aborts any frame and drops the held byte.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      index_q      <= '0;
      serial_q     <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      shift_q      <= shift_n;
      hold_q       <= hold_n;
      hold_valid_q <= hold_valid_n;
      index_q      <= index_n;
      serial_q     <= serial_n;
      active_q     <= active_n;
      done_q       <= done_n;
    end
  end

  assign tx.o_TX_Ready  = !hold_valid_q;
  assign tx.o_TX_Serial = serial_q;
  assign tx.o_TX_Active = active_q;
  assign tx.o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a per-clock line model
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int F = NBITS * CPB;

  typedef logic line_q_t[$];

  logic i_Clock = 1'b0;
  logic i_Reset;
  int   errors = 0;
  int   checks = 0;

  uart_tx_if tx();

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .tx      (tx)
  );

  always #5 i_Clock = ~i_Clock;

  // Expected line level for every clock of one frame of byte b.
  function automatic line_q_t frame_line(input logic [7:0] b);
    line_q_t bits;
    line_q_t line;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(($countones(b) % 2) == 1);
`endif
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int r = 0; r < CPB; r++) line.push_back(bits[k]);
    return line;
  endfunction

  task automatic test_reset();
    i_Reset = 1'b1;
    tx.i_TX_DV = 1'b0;
    tx.i_TX_Byte = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_Clock);
      checks++; if (tx.o_TX_Serial !== 1'b1) begin errors++; $display("FAIL reset_serial c=%0d got=%b want=1", c, tx.o_TX_Serial); end
      checks++; if (tx.o_TX_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready c=%0d got=%b want=1", c, tx.o_TX_Ready); end
      checks++; if (tx.o_TX_Active !== 1'b0) begin errors++; $display("FAIL reset_active c=%0d got=%b want=0", c, tx.o_TX_Active); end
      checks++; if (tx.o_TX_Done !== 1'b0) begin errors++; $display("FAIL reset_done c=%0d got=%b want=0", c, tx.o_TX_Done); end
    end
    i_Reset = 1'b0;
    @(negedge i_Clock);
  endtask

  task automatic test_frame(input logic [7:0] b);
    line_q_t exp = frame_line(b);
    logic want_serial, want_active, want_done;
    tx.i_TX_DV = 1'b1;
    tx.i_TX_Byte = b;
    @(negedge i_Clock);
    tx.i_TX_DV = 1'b0;
    for (int c = 0; c <= F + 1; c++) begin
      want_serial = (c < F) ? exp[c] : 1'b1;
      want_active = (c < F);
      want_done   = (c == F);
      checks++; if (tx.o_TX_Serial !== want_serial) begin errors++; $display("FAIL frame_serial byte=%h c=%0d got=%b want=%b", b, c, tx.o_TX_Serial, want_serial); end
      checks++; if (tx.o_TX_Active !== want_active) begin errors++; $display("FAIL frame_active byte=%h c=%0d got=%b want=%b", b, c, tx.o_TX_Active, want_active); end
      checks++; if (tx.o_TX_Done !== want_done) begin errors++; $display("FAIL frame_done byte=%h c=%0d got=%b want=%b", b, c, tx.o_TX_Done, want_done); end
      checks++; if (tx.o_TX_Ready !== 1'b1) begin errors++; $display("FAIL frame_ready byte=%h c=%0d got=%b want=1", b, c, tx.o_TX_Ready); end
      tx.i_TX_Byte = 8'($urandom);
      @(negedge i_Clock);
    end
  endtask

  // Second byte offered while sampling cycle acc; an overrun byte follows if the holder is full.
  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1, input int acc);
    line_q_t exp = frame_line(b0);
    line_q_t e1 = frame_line(b1);
    logic want_serial, want_active, want_done, want_ready;
    foreach (e1[k]) exp.push_back(e1[k]);
    tx.i_TX_DV = 1'b1;
    tx.i_TX_Byte = b0;
    @(negedge i_Clock);
    tx.i_TX_DV = 1'b0;
    for (int c = 0; c <= 2 * F + 1; c++) begin
      want_serial = (c < 2 * F) ? exp[c] : 1'b1;
      want_active = (c < 2 * F);
      want_done   = (c == F) || (c == 2 * F);
      want_ready  = !((c >= acc + 1) && (c < F));
      checks++; if (tx.o_TX_Serial !== want_serial) begin errors++; $display("FAIL b2b_serial acc=%0d c=%0d got=%b want=%b", acc, c, tx.o_TX_Serial, want_serial); end
      checks++; if (tx.o_TX_Active !== want_active) begin errors++; $display("FAIL b2b_active acc=%0d c=%0d got=%b want=%b", acc, c, tx.o_TX_Active, want_active); end
      checks++; if (tx.o_TX_Done !== want_done) begin errors++; $display("FAIL b2b_done acc=%0d c=%0d got=%b want=%b", acc, c, tx.o_TX_Done, want_done); end
      checks++; if (tx.o_TX_Ready !== want_ready) begin errors++; $display("FAIL b2b_ready acc=%0d c=%0d got=%b want=%b", acc, c, tx.o_TX_Ready, want_ready); end
      tx.i_TX_DV = 1'b0;
      tx.i_TX_Byte = 8'($urandom);
      if (c == acc) begin
        tx.i_TX_DV = 1'b1;
        tx.i_TX_Byte = b1;
      end else if ((c == acc + 4) && (acc + 4 < F)) begin
        tx.i_TX_DV = 1'b1;
        tx.i_TX_Byte = 8'hFF;
      end
      @(negedge i_Clock);
    end
    tx.i_TX_DV = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    line_q_t exp = frame_line(8'h00);
    int rst_at = 4 * CPB + 1;
    tx.i_TX_DV = 1'b1;
    tx.i_TX_Byte = 8'h00;
    @(negedge i_Clock);
    tx.i_TX_DV = 1'b0;
    for (int c = 0; c <= rst_at; c++) begin
      checks++; if (tx.o_TX_Serial !== exp[c]) begin errors++; $display("FAIL mid_serial c=%0d got=%b want=%b", c, tx.o_TX_Serial, exp[c]); end
      checks++; if (tx.o_TX_Ready !== (c <= 2 * CPB)) begin errors++; $display("FAIL mid_ready c=%0d got=%b want=%b", c, tx.o_TX_Ready, (c <= 2 * CPB)); end
      tx.i_TX_DV = (c == 2 * CPB);
      tx.i_TX_Byte = 8'($urandom);
      if (c == rst_at) i_Reset = 1'b1;
      @(negedge i_Clock);
    end
    tx.i_TX_DV = 1'b0;
    i_Reset = 1'b0;
    checks++; if (tx.o_TX_Serial !== 1'b1) begin errors++; $display("FAIL mid_rst_serial got=%b want=1", tx.o_TX_Serial); end
    checks++; if (tx.o_TX_Ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b want=1", tx.o_TX_Ready); end
    checks++; if (tx.o_TX_Active !== 1'b0) begin errors++; $display("FAIL mid_rst_active got=%b want=0", tx.o_TX_Active); end
    checks++; if (tx.o_TX_Done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%b want=0", tx.o_TX_Done); end
    for (int k = 0; k < 2 * F; k++) begin
      @(negedge i_Clock);
      checks++; if ((tx.o_TX_Serial !== 1'b1) || (tx.o_TX_Active !== 1'b0) || (tx.o_TX_Done !== 1'b0)) begin
        errors++; $display("FAIL mid_quiet k=%0d got serial=%b active=%b done=%b want 1/0/0", k, tx.o_TX_Serial, tx.o_TX_Active, tx.o_TX_Done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'h55);
    repeat (4) test_frame(8'($urandom));
    test_back_to_back(8'hA3, 8'h0F, 3 * CPB);
    test_back_to_back(8'($urandom), 8'($urandom), F - 1);
    repeat (3) test_back_to_back(8'($urandom), 8'($urandom), $urandom_range(0, F - 1));
    test_reset_mid_frame();
    test_frame(8'h81);
    test_frame(8'hA5);
    test_frame(8'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's UART receiver, sharing the same frame format and bit timing.
- Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1); no flow control.
- Contains a one-byte holding register, so the next byte can be accepted mid-frame and frames go out back-to-back with no idle gap.
- Sits between an internal byte producer (command/response logic) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 10416, clocks per bit period (clock freq / baud); legal range >= 2; elaboration error if violated.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  reset; synchronous, active-high.
- i_TX_DV  input  1  byte-valid strobe; a byte is accepted on any edge where i_TX_DV && o_TX_Ready.
- i_TX_Byte  input  8  byte to send; sampled only on acceptance.
- o_TX_Ready  output  1  high when a byte can be accepted, i.e. the holding register is empty.
- o_TX_Serial  output  1  serial line, registered; idles high.
- o_TX_Active  output  1  high while any frame bit (start through stop) is driven.
- o_TX_Done  output  1  one-clock pulse on the edge that ends each stop bit.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0.
  - state=IDLE; bit counter, bit index and holding-valid flag cleared.
- Reset mid-frame: the frame is aborted, the line is high on the next cycle, and any held byte is discarded.
- States: IDLE, TX_START_BIT, TX_DATA_BITS, [TX_PARITY_BIT], TX_STOP_BIT.
- Bit timer:
  - Counter width $clog2(CLKS_PER_BIT).
  - Each bit is driven for exactly CLKS_PER_BIT clocks; the counter runs 0..CLKS_PER_BIT-1, then wraps to 0 and the next bit starts.
- IDLE:
  - o_TX_Serial=1, o_TX_Active=0.
  - On acceptance, the byte loads the shift register directly (holding register stays empty) and the state goes to TX_START_BIT.
  - o_TX_Serial=0 and o_TX_Active=1 are both visible after that same edge.
  - Latency from the accepting edge to the start bit on the line: 0 cycles.
- TX_START_BIT: drive 0 for CLKS_PER_BIT clocks, then TX_DATA_BITS with index 0.
- TX_DATA_BITS:
  - Drive shift[index] for CLKS_PER_BIT clocks; index increments 0..7.
  - After index 7, go to TX_PARITY_BIT if the optional feature is compiled in, else TX_STOP_BIT.
- TX_STOP_BIT: drive 1 for CLKS_PER_BIT clocks. On the final edge:
  - o_TX_Done pulses for one cycle.
  - If the holding register is valid: its byte moves to the shift register, the holding register clears, and the state goes to TX_START_BIT (no idle gap).
  - Else if i_TX_DV is high on this same edge (Ready is high): the new byte goes straight into the shift register and the state goes to TX_START_BIT.
  - Else: state goes to IDLE and o_TX_Active falls.
- Acceptance while busy: the byte is written to the holding register and o_TX_Ready drops on the next cycle.
- i_TX_DV while o_TX_Ready=0: ignored; the byte is dropped and no state changes.
- i_TX_Byte changes after acceptance have no effect on the frame in flight.
- Total frame length: 10*CLKS_PER_BIT clocks (11*CLKS_PER_BIT with parity).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - TX_PARITY_BIT state is inserted after data bit 7.
  - It drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks.
  - Frame is 11 bits.
- Undefined: the state and the parity logic are absent; frame is 10 bits.
- The receiver must be built with the matching setting.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W=8.
  - DEFAULT_CLKS_PER_BIT=10416.
  - Shared tx state enum typedef tx_state_t.
- The receiver is migrated to uart_pkg later.
- Sub-module uart_bit_timer (param CLKS_PER_BIT; inputs clear/enable; output last-cycle tick) is natural and is reusable by the receiver.

Test Plan:
- Reset line: assert i_Reset for 3 clocks -> Serial=1, Ready=1, Active=0, Done=0 on every cycle after the first reset edge.
- Single frame: CLKS_PER_BIT=4, send 0x55 ->
  - Serial bit sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 clocks.
  - Done pulses once, 40 clocks after acceptance.
  - Active falls on the next cycle.
- Back-to-back: CLKS_PER_BIT=4, accept 0xA3, then 0x0F during data bits ->
  - Ready low until 0x0F leaves the holding register.
  - Second start bit immediately follows the first stop bit (80 contiguous clocks).
  - Done pulses twice.
- Overrun drop: holding register full, pulse i_TX_DV with 0xFF -> no state change; only the two earlier bytes appear on the line.
- Reset mid-frame: assert i_Reset during data bit 3 of 0x00 -> Serial=1 next cycle, Ready=1, Active=0, no Done; a new 0x81 afterwards transmits correctly.
- Parity (UART_TX_PARITY_EN defined): send 0xA5 -> parity bit 0 (four ones), frame 11*CLKS_PER_BIT; send 0x01 -> parity bit 1.
